// File: rtl/ps2_mouse_packet_rx.sv
// Receive-only PS/2 mouse front end: deserialises device-to-host frames, assembles
// 3-byte stream packets and keeps a clamped absolute cursor plus button states.
module ps2_mouse_packet_rx #(
    parameter int unsigned TIMEOUT_CYC = 20000,
    parameter int unsigned SCREEN_W    = 96,
    parameter int unsigned SCREEN_H    = 64,
    parameter int unsigned X_INIT      = 48,
    parameter int unsigned Y_INIT      = 32
) (
    input  logic       basys_clock,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [6:0] cursor_x,
    output logic [5:0] cursor_y,
    output logic       btn_left,
    output logic       btn_right,
    output logic       btn_middle,
    output logic       pkt_valid,
    output logic       frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic signed [10:0] XMax = 11'(SCREEN_W - 1);
    localparam logic signed [10:0] YMax = 11'(SCREEN_H - 1);

    typedef enum logic {FrIdle, FrShift} fr_state_e;
    typedef enum logic [1:0] {PkB0, PkB1, PkB2} pk_state_e;

    // Reset asserts asynchronously, releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_core_n;

    always_ff @(posedge basys_clock or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_core_n = rst_sync_q[1];

    logic [1:0] clk_sync_q, data_sync_q;
    logic [3:0] hist_q;
    logic       filt_q, filt_d, fall_q;

    always_comb begin
        filt_d = filt_q;
        if (&hist_q)       filt_d = 1'b1;
        else if (~|hist_q) filt_d = 1'b0;
    end

    always_ff @(posedge basys_clock or negedge rst_core_n) begin
        if (!rst_core_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            hist_q      <= 4'hF;
            filt_q      <= 1'b1;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            hist_q      <= {hist_q[2:0], clk_sync_q[1]};
            filt_q      <= filt_d;
            fall_q      <= filt_q & ~filt_d;
        end
    end

    fr_state_e     fr_q, fr_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [9:0]    sh_q, sh_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          byte_ok_q, byte_ok_d, err_q, err_d;
    logic          data_s;

    assign data_s = data_sync_q[1];

    always_comb begin
        fr_d      = fr_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        tmo_d     = '0;
        rx_byte_d = rx_byte_q;
        byte_ok_d = 1'b0;
        err_d     = 1'b0;
        unique case (fr_q)
            FrIdle: begin
                if (fall_q) begin
                    sh_d  = {data_s, sh_q[9:1]};
                    cnt_d = 4'd1;
                    fr_d  = FrShift;
                end
            end
            FrShift: begin
                if (fall_q) begin
                    if (cnt_q == 4'd10) begin
                        // sh_q holds start in [0], data in [8:1], parity in [9]
                        if (!sh_q[0] && data_s && (^sh_q[9:1])) begin
                            byte_ok_d = 1'b1;
                            rx_byte_d = sh_q[8:1];
                        end else begin
                            err_d = 1'b1;
                        end
                        cnt_d = 4'd0;
                        fr_d  = FrIdle;
                    end else begin
                        sh_d  = {data_s, sh_q[9:1]};
                        cnt_d = cnt_q + 4'd1;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    err_d = 1'b1;
                    cnt_d = 4'd0;
                    fr_d  = FrIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: fr_d = FrIdle;
        endcase
    end

    always_ff @(posedge basys_clock or negedge rst_core_n) begin
        if (!rst_core_n) begin
            fr_q      <= FrIdle;
            cnt_q     <= '0;
            sh_q      <= '0;
            tmo_q     <= '0;
            rx_byte_q <= '0;
            byte_ok_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            fr_q      <= fr_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            tmo_q     <= tmo_d;
            rx_byte_q <= rx_byte_d;
            byte_ok_q <= byte_ok_d;
            err_q     <= err_d;
        end
    end

    pk_state_e         pk_q, pk_d;
    // hdr: {y_ovf, x_ovf, y_sign, x_sign, middle, right, left}
    logic [6:0]        hdr_q, hdr_d;
    logic [7:0]        b1_q, b1_d;
    logic [6:0]        x_q, x_d, x_clamp;
    logic [5:0]        y_q, y_d, y_clamp;
    logic [2:0]        btn_q, btn_d;
    logic              valid_q, valid_d;
    logic signed [10:0] dx, dy, nx, ny;

    always_comb begin
        dx = hdr_q[5] ? 11'sd0 : $signed({{3{hdr_q[3]}}, b1_q});
        dy = hdr_q[6] ? 11'sd0 : $signed({{3{hdr_q[4]}}, rx_byte_q});
        nx = $signed({4'b0, x_q}) + dx;
        ny = $signed({5'b0, y_q}) - dy;
        if (nx < 11'sd0)     x_clamp = '0;
        else if (nx > XMax)  x_clamp = XMax[6:0];
        else                 x_clamp = nx[6:0];
        if (ny < 11'sd0)     y_clamp = '0;
        else if (ny > YMax)  y_clamp = YMax[5:0];
        else                 y_clamp = ny[5:0];
    end

    always_comb begin
        pk_d    = pk_q;
        hdr_d   = hdr_q;
        b1_d    = b1_q;
        x_d     = x_q;
        y_d     = y_q;
        btn_d   = btn_q;
        valid_d = 1'b0;
        if (err_q) begin
            pk_d = PkB0;
        end else if (byte_ok_q) begin
            unique case (pk_q)
                PkB0: begin
                    // Bit 3 is always set in a header byte; anything else is a resync drop.
                    if (rx_byte_q[3]) begin
                        hdr_d = {rx_byte_q[7:4], rx_byte_q[2:0]};
                        pk_d  = PkB1;
                    end
                end
                PkB1: begin
                    b1_d = rx_byte_q;
                    pk_d = PkB2;
                end
                PkB2: begin
                    x_d     = x_clamp;
                    y_d     = y_clamp;
                    btn_d   = hdr_q[2:0];
                    valid_d = 1'b1;
                    pk_d    = PkB0;
                end
                default: pk_d = PkB0;
            endcase
        end
    end

    always_ff @(posedge basys_clock or negedge rst_core_n) begin
        if (!rst_core_n) begin
            pk_q    <= PkB0;
            hdr_q   <= '0;
            b1_q    <= '0;
            x_q     <= 7'(X_INIT);
            y_q     <= 6'(Y_INIT);
            btn_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            pk_q    <= pk_d;
            hdr_q   <= hdr_d;
            b1_q    <= b1_d;
            x_q     <= x_d;
            y_q     <= y_d;
            btn_q   <= btn_d;
            valid_q <= valid_d;
        end
    end

    assign cursor_x   = x_q;
    assign cursor_y   = y_q;
    assign btn_left   = btn_q[0];
    assign btn_right  = btn_q[1];
    assign btn_middle = btn_q[2];
    assign pkt_valid  = valid_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// Directed bench for ps2_mouse_packet_rx: a cursor/button model fed by the stimulus
// plus a per-cycle compare process, with literal spot checks pinning the model.
module tb_ps2_mouse_packet_rx;

    // PS/2 clock scaled down (and timeout shortened) to keep the run short.
    localparam int unsigned TMO  = 1000;
    localparam int unsigned HALF = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [6:0] cursor_x;
    logic [5:0] cursor_y;
    logic       btn_left, btn_right, btn_middle, pkt_valid, frame_err;

    always #5 clk = ~clk;

    ps2_mouse_packet_rx #(
        .TIMEOUT_CYC(TMO),
        .SCREEN_W   (96),
        .SCREEN_H   (64),
        .X_INIT     (48),
        .Y_INIT     (32)
    ) dut (
        .basys_clock(clk),
        .rst_n      (rst_n),
        .ps2_clk_in (ps2_clk),
        .ps2_data_in(ps2_data),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_middle (btn_middle),
        .pkt_valid  (pkt_valid),
        .frame_err  (frame_err)
    );

    typedef struct {
        int         x;
        int         y;
        logic [2:0] btn;
    } st_t;

    int         n_checks = 0;
    int         n_fail = 0;
    st_t        exp_q[$];
    int         mx = 48, my = 32;
    logic [2:0] mbtn = 3'b000;
    int         hx = 48, hy = 32;
    logic [2:0] hbtn = 3'b000;
    int         pkt_seen = 0, pkt_exp = 0, err_seen = 0, err_exp = 0;
    logic       prev_pv = 1'b0, prev_fe = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // Packet semantics from the byte layout, in plain integer arithmetic.
    task automatic model_apply(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int dx, dy;
        dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
        dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
        mx = clampi(mx + dx, 95);
        my = clampi(my - dy, 63);
        mbtn = b0[2:0];
        exp_q.push_back('{mx, my, mbtn});
        pkt_exp++;
    endtask

    always @(negedge clk) begin
        st_t e;
        if (!rst_n) begin
            hx = 48;
            hy = 32;
            hbtn = 3'b000;
            check("rst_cursor_x", int'(cursor_x), 48);
            check("rst_cursor_y", int'(cursor_y), 32);
            check("rst_buttons", int'({btn_middle, btn_right, btn_left}), 0);
            check("rst_pulses", int'({pkt_valid, frame_err}), 0);
        end else begin
            check("pv_fe_exclusive", int'(pkt_valid & frame_err), 0);
            check("pv_one_cycle", int'(pkt_valid & prev_pv), 0);
            check("fe_one_cycle", int'(frame_err & prev_fe), 0);
            if (pkt_valid) begin
                pkt_seen++;
                check("pkt_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    hx = e.x;
                    hy = e.y;
                    hbtn = e.btn;
                end
            end
            if (frame_err) err_seen++;
            check("cursor_x", int'(cursor_x), hx);
            check("cursor_y", int'(cursor_y), hy);
            check("buttons", int'({btn_middle, btn_right, btn_left}), int'(hbtn));
        end
        prev_pv = pkt_valid;
        prev_fe = frame_err;
    end

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(posedge clk);
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        model_apply(b0, b1, b2);
        send_byte(b0, 1'b0);
        send_byte(b1, 1'b0);
        send_byte(b2, 1'b0);
    endtask

    task automatic settle(input string tag);
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (20) @(posedge clk);
        check({tag, "_drain"}, exp_q.size(), 0);
        check({tag, "_pkt_count"}, pkt_seen, pkt_exp);
        check({tag, "_err_count"}, err_seen, err_exp);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        mx = 48;
        my = 32;
        mbtn = 3'b000;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_x_literal", int'(cursor_x), 48);
        check("reset_y_literal", int'(cursor_y), 32);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    initial begin
        #800us;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        send_packet(8'h08, 8'h05, 8'h03);
        settle("basic");
        check("basic_x_literal", int'(cursor_x), 53);
        check("basic_y_literal", int'(cursor_y), 29);
        check("basic_btn_literal", int'({btn_middle, btn_right, btn_left}), 0);

        send_packet(8'h18, 8'hD5, 8'h00);
        settle("move_left");
        check("move_left_x_literal", int'(cursor_x), 10);

        send_packet(8'h19, 8'hF0, 8'h00);
        settle("clamp_x0");
        check("clamp_x0_literal", int'(cursor_x), 0);
        check("btn_left_literal", int'(btn_left), 1);

        send_packet(8'h28, 8'h00, 8'hFD);
        settle("move_down");
        check("move_down_y_literal", int'(cursor_y), 32);

        send_packet(8'h28, 8'h00, 8'h80);
        settle("clamp_y63");
        check("clamp_y63_literal", int'(cursor_y), 63);

        send_packet(8'h08, 8'h20, 8'h00);
        send_packet(8'h48, 8'h7F, 8'h00);
        settle("x_overflow");
        check("x_overflow_literal", int'(cursor_x), 32);

        send_byte(8'h08, 1'b1);
        err_exp++;
        settle("bad_parity_b0");
        send_byte(8'h08, 1'b0);
        send_byte(8'h05, 1'b1);
        err_exp++;
        settle("bad_parity_b1");
        send_byte(8'h05, 1'b0);
        send_packet(8'h08, 8'h01, 8'h01);
        settle("resync");
        check("resync_x_literal", int'(cursor_x), 33);
        check("resync_y_literal", int'(cursor_y), 62);

        for (int i = 0; i < 5; i++) ps2_bit((i == 4) ? 1'b1 : 1'b0);
        ps2_data = 1'b1;
        repeat (TMO + 300) @(posedge clk);
        err_exp++;
        settle("timeout");
        send_packet(8'h08, 8'h02, 8'h00);
        settle("after_timeout");
        check("after_timeout_x_literal", int'(cursor_x), 35);

        send_byte(8'h08, 1'b0);
        for (int i = 0; i < 6; i++) ps2_bit(i[0]);
        ps2_data = 1'b1;
        do_reset();
        send_packet(8'h08, 8'h05, 8'h03);
        settle("after_reset");
        check("after_reset_x_literal", int'(cursor_x), 53);
        check("after_reset_y_literal", int'(cursor_y), 29);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
